// File: rtl/belt_sort_pkg.sv
// rtl/belt_sort_pkg.sv - controller states and waste class encodings for the belt sorter
package belt_sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    SAMPLE,
    DISPATCH,
    CLEAR,
    FAULT
  } state_t;

  localparam logic [1:0] DRY   = 2'd0;
  localparam logic [1:0] METAL = 2'd1;
  localparam logic [1:0] WET   = 2'd2;
  localparam logic [1:0] MIXED = 2'd3;

  function automatic logic [1:0] classify(input logic metal_major, input logic wet_major);
    case ({metal_major, wet_major})
      2'b11:   return MIXED;
      2'b10:   return METAL;
      2'b01:   return WET;
      default: return DRY;
    endcase
  endfunction

endpackage

// File: rtl/sort_debounce.sv
// rtl/sort_debounce.sv - 2-flop synchroniser, counting debouncer and registered rising-edge pulse
module sort_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/belt_sort_ctrl.sv
// rtl/belt_sort_ctrl.sv - belt stop/settle/sample/dispatch sequencer in front of the stepper driver
module belt_sort_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SETTLE_CYC   = 2500000,
  parameter int SAMPLE_CYC   = 5000000,
  parameter int TIMEOUT_CYC  = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       obj_sensor,
  input  logic       metal_sensor,
  input  logic       wet_sensor,
  input  logic       sort_ack,
  output logic       ON_belt,
  output logic       OFF_belt,
  output logic       sort_valid,
  output logic [1:0] sort_class,
  output logic       belt_running,
  output logic       fault
);
  import belt_sort_pkg::*;

  localparam int CNT_W = 32;
  localparam int SW    = $clog2(SAMPLE_CYC + 1);
  localparam logic [SW-1:0] HALF = SW'(SAMPLE_CYC / 2);

  logic start_lvl, start_rise, stop_lvl, stop_rise, obj_lvl, obj_rise;
  logic unused_levels;

  sort_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
    .clk(clk), .rst(rst), .raw_i(start_btn), .level_o(start_lvl), .rise_o(start_rise));
  sort_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop (
    .clk(clk), .rst(rst), .raw_i(stop_btn), .level_o(stop_lvl), .rise_o(stop_rise));
  sort_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_obj (
    .clk(clk), .rst(rst), .raw_i(obj_sensor), .level_o(obj_lvl), .rise_o(obj_rise));

  assign unused_levels = start_lvl ^ stop_lvl;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]      metal_cnt_q, metal_cnt_d, wet_cnt_q, wet_cnt_d;
  logic [SW-1:0]      metal_tot, wet_tot;
  logic               metal_s1_q, metal_s_q, wet_s1_q, wet_s_q;
  logic               on_q, on_d, off_q, off_d, valid_q, valid_d, fault_q, fault_d;
  logic [1:0]         class_q, class_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    metal_cnt_d = metal_cnt_q;
    wet_cnt_d   = wet_cnt_q;
    metal_tot   = metal_cnt_q + SW'(metal_s_q);
    wet_tot     = wet_cnt_q + SW'(wet_s_q);
    on_d        = 1'b0;
    off_d       = 1'b0;
    valid_d     = valid_q;
    class_d     = class_q;
    fault_d     = fault_q;

    // Stop outranks every other event in the same cycle.
    if (stop_rise) begin
      off_d   = 1'b1;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_rise) begin
          on_d    = 1'b1;
          state_d = RUN;
        end
        RUN: if (obj_rise) begin
          off_d   = 1'b1;
          state_d = SETTLE;
        end
        SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = SAMPLE;
        SAMPLE: begin
          metal_cnt_d = metal_tot;
          wet_cnt_d   = wet_tot;
          if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
            class_d = classify(metal_tot > HALF, wet_tot > HALF);
            valid_d = 1'b1;
            state_d = DISPATCH;
          end
        end
        DISPATCH: begin
          if (sort_ack) begin
            valid_d = 1'b0;
            on_d    = 1'b1;
            state_d = CLEAR;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            valid_d = 1'b0;
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
        CLEAR: if (!obj_lvl) state_d = RUN;
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d       = '0;
      metal_cnt_d = '0;
      wet_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      metal_cnt_q <= '0;
      wet_cnt_q   <= '0;
      metal_s1_q  <= 1'b0;
      metal_s_q   <= 1'b0;
      wet_s1_q    <= 1'b0;
      wet_s_q     <= 1'b0;
      on_q        <= 1'b0;
      off_q       <= 1'b0;
      valid_q     <= 1'b0;
      class_q     <= DRY;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      metal_cnt_q <= metal_cnt_d;
      wet_cnt_q   <= wet_cnt_d;
      metal_s1_q  <= metal_sensor;
      metal_s_q   <= metal_s1_q;
      wet_s1_q    <= wet_sensor;
      wet_s_q     <= wet_s1_q;
      on_q        <= on_d;
      off_q       <= off_d;
      valid_q     <= valid_d;
      class_q     <= class_d;
      fault_q     <= fault_d;
    end
  end

  assign ON_belt      = on_q;
  assign OFF_belt     = off_q;
  assign sort_valid   = valid_q;
  assign sort_class   = class_q;
  assign fault        = fault_q;
  assign belt_running = (state_q == RUN) || (state_q == CLEAR);

endmodule

// File: tb/tb_belt_sort_ctrl.sv
// tb/tb_belt_sort_ctrl.sv - randomized scenario bench for belt_sort_ctrl against timing and class rules
module tb_belt_sort_ctrl;

  localparam int DEB = 4;
  localparam int SET = 8;
  localparam int SMP = 10;
  localparam int TMO = 50;
  localparam int LAT = 2 + DEB + 1 + 1;
  localparam int WIN = LAT + SET - 2;
  localparam int VLD = LAT + SET + SMP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_btn = 1'b0, stop_btn = 1'b0, obj_sensor = 1'b0;
  logic metal_sensor = 1'b0, wet_sensor = 1'b0, sort_ack = 1'b0;
  logic ON_belt, OFF_belt, sort_valid, belt_running, fault;
  logic [1:0] sort_class;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int on_cnt = 0, on_cyc = -1, off_cnt = 0, off_cyc = -1;
  int vr_cnt = 0, vr_cyc = -1, vf_cyc = -1, fr_cyc = -1;
  int both_cnt = 0, cls_chg = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;
  logic [1:0] prev_cls = 2'd0;

  belt_sort_ctrl #(
    .DEBOUNCE_CYC(DEB), .SETTLE_CYC(SET), .SAMPLE_CYC(SMP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .obj_sensor(obj_sensor), .metal_sensor(metal_sensor), .wet_sensor(wet_sensor),
    .sort_ack(sort_ack), .ON_belt(ON_belt), .OFF_belt(OFF_belt), .sort_valid(sort_valid),
    .sort_class(sort_class), .belt_running(belt_running), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ON_belt) begin on_cnt++; on_cyc = cyc; end
      if (OFF_belt) begin off_cnt++; off_cyc = cyc; end
      if (ON_belt && OFF_belt) both_cnt++;
      if (sort_valid && !prev_v) begin vr_cnt++; vr_cyc = cyc; end
      if (!sort_valid && prev_v) vf_cyc = cyc;
      if (sort_valid && prev_v && sort_class != prev_cls) cls_chg++;
      if (fault && !prev_f) fr_cyc = cyc;
      prev_v   = sort_valid;
      prev_f   = fault;
      prev_cls = sort_class;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_class(input int m, input int w);
    bit mm, ww;
    mm = m > SMP / 2;
    ww = w > SMP / 2;
    if (mm && ww) return 3;
    if (mm) return 1;
    if (ww) return 2;
    return 0;
  endfunction

  task automatic do_start();
    int t0, c0, hold;
    c0 = on_cnt;
    t0 = cyc;
    hold = $urandom_range(DEB, 12);
    start_btn = 1'b1;
    repeat (hold) step();
    start_btn = 1'b0;
    while (cyc < t0 + LAT + 2) step();
    check("start_on_count", on_cnt, c0 + 1);
    check("start_on_cycle", on_cyc - t0, LAT);
    check("start_running", belt_running, 1);
    repeat (DEB + 6) step();
  endtask

  task automatic do_stop();
    int t0, c0;
    c0 = off_cnt;
    t0 = cyc;
    stop_btn = 1'b1;
    repeat (DEB + 2) step();
    stop_btn = 1'b0;
    while (cyc < t0 + LAT + 2) step();
    check("stop_off_count", off_cnt, c0 + 1);
    check("stop_off_cycle", off_cyc - t0, LAT);
    check("stop_fault", fault, 0);
    check("stop_valid", sort_valid, 0);
    check("stop_running", belt_running, 0);
    repeat (DEB + 6) step();
  endtask

  // Starts in RUN with the object debounced low; ends in RUN again (ack) or IDLE then RUN (timeout).
  task automatic run_round(input int m, input int w, input bit do_ack, input int d);
    bit pm[SMP];
    bit pw[SMP];
    int t0, c, j, off0, on0, vr0, fr0, v;
    bit tmp;
    for (int i = 0; i < SMP; i++) begin
      pm[i] = (i < m);
      pw[i] = (i < w);
    end
    for (int i = SMP - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = pm[i]; pm[i] = pm[j]; pm[j] = tmp;
      j = $urandom_range(0, i);
      tmp = pw[i]; pw[i] = pw[j]; pw[j] = tmp;
    end
    off0 = off_cnt;
    on0  = on_cnt;
    vr0  = vr_cnt;
    fr0  = fr_cyc;
    t0   = cyc;
    obj_sensor   = 1'b1;
    metal_sensor = 1'($urandom_range(0, 1));
    wet_sensor   = 1'($urandom_range(0, 1));
    for (int k = 0; k < VLD + 4; k++) begin
      step();
      c = cyc - t0;
      if (c >= WIN && c < WIN + SMP) begin
        metal_sensor = pm[c - WIN];
        wet_sensor   = pw[c - WIN];
      end else begin
        metal_sensor = 1'($urandom_range(0, 1));
        wet_sensor   = 1'($urandom_range(0, 1));
      end
    end
    check("obj_off_count", off_cnt, off0 + 1);
    check("obj_off_cycle", off_cyc - t0, LAT);
    check("valid_rise_count", vr_cnt, vr0 + 1);
    check("valid_rise_cycle", vr_cyc - off_cyc, SET + SMP);
    check("class", sort_class, exp_class(m, w));
    check("valid_held", sort_valid, 1);
    check("dispatch_running", belt_running, 0);
    v = vr_cyc;
    if (do_ack) begin
      while (cyc < v + d) step();
      sort_ack = 1'b1;
      step();
      sort_ack = 1'b0;
      repeat (3) step();
      check("ack_on_count", on_cnt, on0 + 1);
      check("ack_on_cycle", on_cyc - v, d + 1);
      check("ack_valid_fall", vf_cyc - v, d + 1);
      check("ack_no_fault", fault, 0);
      check("ack_fault_edge", fr_cyc, fr0);
      check("clear_running", belt_running, 1);
      repeat ($urandom_range(5, 20)) step();
      check("held_obj_no_off", off_cnt, off0 + 1);
      check("held_obj_no_valid", vr_cnt, vr0 + 1);
      obj_sensor = 1'b0;
      repeat (DEB + 8) step();
      check("back_to_run", belt_running, 1);
    end else begin
      while (cyc < v + TMO + 3) step();
      check("timeout_valid_fall", vf_cyc - v, TMO);
      check("timeout_fault_rise", fr_cyc - v, TMO);
      check("timeout_fault", fault, 1);
      check("timeout_valid", sort_valid, 0);
      check("timeout_running", belt_running, 0);
      check("timeout_no_off", off_cnt, off0 + 1);
      check("timeout_no_on", on_cnt, on0);
      obj_sensor = 1'b0;
      do_stop();
      do_start();
    end
  endtask

  initial begin
    int c0, t0, off0, vr0, m, w;
    repeat (3) step();
    check("rst_on", ON_belt, 0);
    check("rst_valid", sort_valid, 0);
    rst = 1'b0;
    step();
    step();
    check("reset_on", ON_belt, 0);
    check("reset_off", OFF_belt, 0);
    check("reset_valid", sort_valid, 0);
    check("reset_class", sort_class, 0);
    check("reset_running", belt_running, 0);
    check("reset_fault", fault, 0);

    for (int g = 0; g < 3; g++) begin
      c0 = on_cnt;
      start_btn = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) step();
      start_btn = 1'b0;
      repeat (15) step();
      check("glitch_no_on", on_cnt, c0);
      check("glitch_idle", belt_running, 0);
    end

    do_start();

    run_round(6, 0, 1'b1, 4);
    run_round(5, 10, 1'b1, $urandom_range(4, 20));
    run_round(10, 10, 1'b1, TMO - 1);
    run_round(0, 0, 1'b1, $urandom_range(4, 20));
    run_round(6, 6, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, SMP);
      w = $urandom_range(0, SMP);
      if ($urandom_range(0, 4) == 0) run_round(m, w, 1'b0, 0);
      else run_round(m, w, 1'b1, ($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(4, TMO - 2));
    end

    off0 = off_cnt;
    vr0  = vr_cnt;
    t0   = cyc;
    stop_btn   = 1'b1;
    obj_sensor = 1'b1;
    repeat (DEB + 2) step();
    stop_btn   = 1'b0;
    obj_sensor = 1'b0;
    while (cyc < t0 + LAT + 2) step();
    check("stop_obj_off_count", off_cnt, off0 + 1);
    check("stop_obj_off_cycle", off_cyc - t0, LAT);
    check("stop_obj_idle", belt_running, 0);
    repeat (SET + SMP + 10) step();
    check("stop_obj_no_valid", vr_cnt, vr0);
    check("stop_obj_off_once", off_cnt, off0 + 1);

    do_stop();
    do_start();

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_running", belt_running, 0);
    check("async_rst_off", OFF_belt, 0);
    check("async_rst_on", ON_belt, 0);
    step();
    check("never_on_and_off", both_cnt, 0);
    check("class_stable_while_valid", cls_chg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/belt_sort_ctrl.md
# belt_sort_ctrl

Sorting-cycle controller sitting directly upstream of the conveyor-belt stepper driver. It debounces the operator start/stop buttons and the object-presence sensor and issues one-cycle `ON_belt` / `OFF_belt` commands to the belt driver. Each time an object arrives at the sensing station it stops the belt, lets the object settle, and majority-samples the metal and moisture sensors. It then hands a waste class to the diverter stage over a valid/ack handshake and restarts the belt once the class is accepted.

## Interface
- `DEBOUNCE_CYC`, 500000: consecutive stable cycles before a debounced level changes (10 ms at 50 MHz).
- `SETTLE_CYC`, 2500000: wait after belt stop before sampling.
- `SAMPLE_CYC`, 5000000: sampling window length; must be ≥ 2.
- `TIMEOUT_CYC`, 250000000: maximum wait for `sort_ack`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_btn`  in  1  operator start, raw and asynchronous.
- `stop_btn`  in  1  operator stop, raw and asynchronous.
- `obj_sensor`  in  1  object present at sensing station, raw and asynchronous.
- `metal_sensor`  in  1  inductive sensor, raw and asynchronous.
- `wet_sensor`  in  1  capacitive sensor, raw and asynchronous.
- `sort_ack`  in  1  diverter accepted the class.
- `ON_belt`  out  1  one-cycle pulse: start belt.
- `OFF_belt`  out  1  one-cycle pulse: stop belt.
- `sort_valid`  out  1  class presented to diverter.
- `sort_class`  out  2  0 DRY, 1 METAL, 2 WET, 3 MIXED.
- `belt_running`  out  1  status: belt commanded on.
- `fault`  out  1  diverter timeout latched.

## Operation
- All five raw inputs pass through 2-flop synchronisers.
- `start_btn`, `stop_btn` and `obj_sensor` are then debounced. The debounced level toggles only after the synchronised input differs from it for `DEBOUNCE_CYC` consecutive cycles. Any glitch restarts the count.
- FSM states and transitions:
  - IDLE: belt off. A debounced start rising edge pulses `ON_belt` and moves to RUN.
  - RUN: a debounced obj rising edge pulses `OFF_belt` and moves to SETTLE.
  - SETTLE: after `SETTLE_CYC` cycles, move to SAMPLE.
  - SAMPLE: for exactly `SAMPLE_CYC` cycles, count cycles with synced metal high and cycles with synced wet high. The class is decided from these counts:
    - metal > `SAMPLE_CYC`/2 (integer division) and wet > half: MIXED.
    - metal only above half: METAL.
    - wet only above half: WET.
    - otherwise: DRY.
    - The class is registered into `sort_class`, `sort_valid` is set, and the FSM moves to DISPATCH.
  - DISPATCH: `sort_valid` and `sort_class` are held stable. If `sort_ack` is high in a cycle, `sort_valid` clears, `ON_belt` pulses and the FSM moves to CLEAR. After `TIMEOUT_CYC` cycles without ack, `sort_valid` clears, `fault` is set and the FSM moves to FAULT.
  - CLEAR: belt running. A debounced obj low moves to RUN, so the same object cannot trigger twice.
  - FAULT: belt off, `fault` high. Only stop or `rst` exits.
- A debounced stop rising edge acts in any state:
  - Pulses `OFF_belt`.
  - Clears `sort_valid` and `fault`.
  - Moves to IDLE.
  - In IDLE, stop still pulses `OFF_belt`; this is harmless.
- Simultaneous events:
  - Stop beats start, obj and ack.
  - Ack and timeout in the same cycle: ack wins.
- `ON_belt` and `OFF_belt` are never high in the same cycle.
- `belt_running` is high in RUN and CLEAR, low elsewhere.
- Counters saturate only through reset to 0 on state entry; the sample counters are sized to hold `SAMPLE_CYC`.

## Timing
- Reset values: state IDLE; all outputs 0; all counters and debounced levels 0.
- Pulse latency: `ON_belt` and `OFF_belt` are registered and high for exactly one cycle, namely the first cycle of the new state. That is one clk after the cycle in which the debounced edge is seen.
- Input-to-command latency is 2 (sync) + `DEBOUNCE_CYC` + 1 (edge register) + 1 (output register) cycles.
- `sort_valid` rises in the first DISPATCH cycle, which comes `SETTLE_CYC` + `SAMPLE_CYC` cycles after `OFF_belt`.
- `sort_valid` falls in the cycle after `sort_ack` is sampled high.
- `rst` asserted mid-operation forces IDLE immediately. No `OFF_belt` is issued; the belt driver has its own reset.

## Structure
- Package `belt_sort_pkg`: state enum (IDLE, RUN, SETTLE, SAMPLE, DISPATCH, CLEAR, FAULT) and class constants DRY/METAL/WET/MIXED.
- Sub-module `sort_debounce` (parameter `DEBOUNCE_CYC`; sync + debounce + rising-edge pulse). It is instantiated three times.

## Test plan
Use `DEBOUNCE_CYC`=4, `SETTLE_CYC`=8, `SAMPLE_CYC`=10, `TIMEOUT_CYC`=50.
- Start held 10 cycles → exactly one `ON_belt` pulse 8 cycles after the edge, `belt_running`=1. A 3-cycle start glitch → no pulse.
- Object arrives, metal high 6 of 10 sample cycles, wet 0 → `OFF_belt` pulse, then `sort_valid`=1 with class 1 after 18 cycles. Ack → `ON_belt` pulse, state CLEAR.
- Metal 5 of 10 and wet 10 of 10 → class 2 (5 is not > 5). Both 10 → class 3.
- No ack for 50 cycles → `sort_valid`=0, `fault`=1, belt stays off. Stop → `fault`=0, IDLE, one `OFF_belt` pulse.
- Stop and obj edges debounced in the same cycle while in RUN → `OFF_belt` pulse, state IDLE, no SETTLE entry.
- Object stays on the sensor after ack → no second classification until obj goes low for ≥4 cycles and then rises again.
